fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 Parameter WID, default 32, data width, equal to the FIFO data width.
REQ-003 Parameter DEP, default 8, depth of the downstream syn_fifo (power of 2).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port req_i  input  NREQ  per-requester write request; held with data until granted.
REQ-007 Port data_i  input  NREQ*WID  packed write data; requester k at bits [k*WID +: WID].
REQ-008 Port gnt_o  output  NREQ  one-hot grant, combinational; transfer occurs on the edge where req_i[k] and gnt_o[k] are both 1.
REQ-009 Port fifo_rd_i  input  1  read strobe driven into the FIFO, observed only.
REQ-010 Port fifo_empty_i  input  1  FIFO empty flag.
REQ-011 Port fifo_wr_o  output  1  FIFO write strobe, registered.
REQ-012 Port fifo_wdata_o  output  WID  FIFO write data, registered.
REQ-013 Port level_o  output  $clog2(DEP)+1  tracked occupancy, including the write in flight.
REQ-014 Port full_o  output  1  level_o == DEP.

Function
REQ-015 Grant: round-robin; search starts at ptr+1 mod NREQ, first index with req_i set wins; at most one gnt_o bit set.
REQ-016 gnt_o is all-zero when level_o == DEP or state is STALL; a read in the same cycle does not free a slot until the next cycle.
REQ-017 On a grant to k, ptr <= k; ptr is unchanged on cycles without a grant.
REQ-018 Latency: a grant at edge N drives fifo_wr_o=1 and fifo_wdata_o=data_i[k] during cycle N+1; fifo_wr_o=0 otherwise; fifo_wdata_o holds its last value when fifo_wr_o=0.
REQ-019 Level: +1 on a grant; -1 on fifo_rd_i && !fifo_empty_i; unchanged when both occur; never wraps below 0 or above DEP.
REQ-020 FSM states IDLE (no req_i), RUN (grants issuing), STALL (level == DEP).
REQ-021 Transitions: IDLE->RUN on any req_i with level<DEP; RUN->IDLE when req_i==0; RUN->STALL when level reaches DEP; STALL->RUN when level<DEP and req_i!=0; STALL->IDLE when level<DEP and req_i==0.
REQ-022 fifo_wr_o is never asserted while the tracked level would exceed DEP; the FIFO overflow flag never sets under correct use.
REQ-023 req_i deasserted before its grant: the request is dropped, with no write and no level change.

Reset
REQ-024 rst low asynchronously forces gnt_o=0, fifo_wr_o=0, fifo_wdata_o=0, level_o=0, full_o=0, ptr=NREQ-1 (requester 0 first), state IDLE.
REQ-025 Reset mid-operation discards any in-flight write; the FIFO is reset by the same rst, keeping level consistent.
REQ-026 First grant is possible in the first cycle after rst deasserts.

Configuration
REQ-027 Macro FIFO_WR_ARB_STATS_EN defined: ports grant_cnt_o (output, NREQ*16) and stall_cnt_o (output, 16) exist.
REQ-028 grant_cnt_o holds per-requester 16-bit saturating grant counts; stall_cnt_o counts 16-bit saturating cycles with req_i!=0 and no grant; all counters reset to 0.
REQ-029 Macro undefined: these ports and counters are absent; all other behaviour is identical.

Verification (NREQ=4, DEP=8, WID=32)
REQ-030 After reset, req_i=4'b1111 held, no reads -> grants 0,1,2,3,0,1,2,3; full_o=1 after the 8th grant; no gnt_o afterwards; state STALL.
REQ-031 From full, fifo_rd_i=1 for one cycle -> level_o 8->7; next cycle one grant to requester 0 (ptr was 3); level_o back to 8.
REQ-032 req_i[2]=1 with data_i[2]=32'hDEADBEEF -> gnt_o=4'b0100; the next cycle shows fifo_wr_o=1 and fifo_wdata_o=32'hDEADBEEF; the following cycle shows fifo_wr_o=0.
REQ-033 level_o=3, grant and valid read in the same cycle -> level_o stays 3.
REQ-034 rst low mid-burst at level_o=5 -> all outputs 0 immediately, without waiting for a clock edge; after release, req_i=4'b1010 -> first grant to requester 1.
REQ-035 With FIFO_WR_ARB_STATS_EN, 70000 grants to requester 0 -> grant_cnt_o[15:0]=16'hFFFF (saturated).

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a syn_fifo, tracking occupancy so writes never overflow.
// Optional grant/stall statistics counters are enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb #(
    parameter int NREQ = 4,
    parameter int WID  = 32,
    parameter int DEP  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_i,
    input  logic [NREQ*WID-1:0]       data_i,
    output logic [NREQ-1:0]           gnt_o,
    input  logic                      fifo_rd_i,
    input  logic                      fifo_empty_i,
    output logic                      fifo_wr_o,
    output logic [WID-1:0]            fifo_wdata_o,
    output logic [$clog2(DEP):0]      level_o,
    output logic                      full_o
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]        grant_cnt_o,
    output logic [15:0]               stall_cnt_o
`endif
);

    localparam int          PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          LW    = $clog2(DEP) + 1;
    localparam int unsigned NR    = NREQ;
    localparam logic [LW-1:0] DEP_L = LW'(DEP);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic            wr_q;
    logic [WID-1:0]  wdata_q;

    logic            full;
    logic            grant_en;
    logic            found;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            any_gnt;
    logic            rd_ok;

    assign full = (level_q == DEP_L);

    // Search order starts just after the last winner; reset is folded in so gnt_o drops asynchronously.
    always_comb begin
        gnt      = '0;
        gnt_idx  = ptr_q;
        found    = 1'b0;
        cand     = '0;
        grant_en = rst && !full && (state_q != STALL);
        for (int unsigned i = 1; i <= NR; i++) begin
            cand = PW'((32'(ptr_q) + i) % NR);
            if (grant_en && !found && req_i[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                found     = 1'b1;
            end
        end
    end

    assign any_gnt = |gnt;
    assign rd_ok   = fifo_rd_i && !fifo_empty_i && (level_q != '0);

    always_comb begin
        level_d = level_q;
        case ({any_gnt, rd_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Transitions look at the next level so STALL coincides exactly with a full count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i != '0)
                    state_d = (level_d == DEP_L) ? STALL : RUN;
            end
            RUN: begin
                if (level_d == DEP_L)
                    state_d = STALL;
                else if (req_i == '0)
                    state_d = IDLE;
            end
            STALL: begin
                if (level_d != DEP_L)
                    state_d = (req_i != '0) ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            level_q <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            wr_q    <= any_gnt;
            if (any_gnt) begin
                ptr_q   <= gnt_idx;
                wdata_q <= data_i[32'(gnt_idx)*WID +: WID];
            end
        end
    end

    assign gnt_o        = gnt;
    assign fifo_wr_o    = wr_q;
    assign fifo_wdata_o = wdata_q;
    assign level_o      = level_q;
    assign full_o       = full;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_q;

    for (genvar k = 0; k < NREQ; k++) begin : g_gcnt
        logic [15:0] cnt_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                cnt_q <= '0;
            else if (gnt[k] && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
        assign grant_cnt_o[k*16 +: 16] = cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else if ((req_i != '0) && !any_gnt && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed vector table, hand-written corner sequences and a randomized
// run against an occupancy/round-robin reference model. Define FIFO_WR_ARB_STATS_EN to cover counters.
module tb_fifo_wr_arb;

    localparam int NREQ = 4;
    localparam int WID  = 32;
    localparam int DEP  = 8;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*WID-1:0]  data_i;
    logic [NREQ-1:0]      gnt_o;
    logic                 fifo_rd_i;
    logic                 fifo_empty_i;
    logic                 fifo_wr_o;
    logic [WID-1:0]       fifo_wdata_o;
    logic [$clog2(DEP):0] level_o;
    logic                 full_o;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [NREQ*16-1:0]   grant_cnt_o;
    logic [15:0]          stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    fifo_wr_arb #(.NREQ(NREQ), .WID(WID), .DEP(DEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .data_i       (data_i),
        .gnt_o        (gnt_o),
        .fifo_rd_i    (fifo_rd_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_wr_o    (fifo_wr_o),
        .fifo_wdata_o (fifo_wdata_o),
        .level_o      (level_o),
        .full_o       (full_o)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .grant_cnt_o  (grant_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req_i        = '0;
        fifo_rd_i    = 1'b0;
        fifo_empty_i = 1'b1;
        rst          = 1'b0;
        #1;
        chk("rst_gnt",   64'(gnt_o), 64'h0);
        chk("rst_wr",    64'(fifo_wr_o), 64'h0);
        chk("rst_wdata", 64'(fifo_wdata_o), 64'h0);
        chk("rst_level", 64'(level_o), 64'h0);
        chk("rst_full",  64'(full_o), 64'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Winner is the requester closest (cyclically) after the last winner.
    function automatic int rr_pick(input logic [NREQ-1:0] req, input int last);
        int best  = -1;
        int bestd = NREQ;
        for (int k = 0; k < NREQ; k++) begin
            int d;
            d = (k - last - 1 + 2 * NREQ) % NREQ;
            if (req[k] && d < bestd) begin
                bestd = d;
                best  = k;
            end
        end
        return best;
    endfunction

    typedef struct {
        logic [3:0] req;
        logic       rd;
        logic       empty;
        logic [3:0] exp_gnt;
        int         exp_level;
        logic       exp_full;
        logic       exp_wr;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [WID-1:0] lane;
        int             m_level;
        int             m_ptr;
        logic           m_wr;
        logic [WID-1:0] m_wdata;
        int             rd_pct;
        int             w;

        rst          = 1'b0;
        req_i        = '0;
        data_i       = '0;
        fifo_rd_i    = 1'b0;
        fifo_empty_i = 1'b1;

        //            req     rd    empty gnt     lvl full  wr
        tbl[0]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 0, 1'b0, 1'b0};
        tbl[1]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 1, 1'b0, 1'b1};
        tbl[2]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 2, 1'b0, 1'b1};
        tbl[3]  = '{4'b1111, 1'b0, 1'b1, 4'b1000, 3, 1'b0, 1'b1};
        tbl[4]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 4, 1'b0, 1'b1};
        tbl[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 5, 1'b0, 1'b1};
        tbl[6]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 6, 1'b0, 1'b1};
        tbl[7]  = '{4'b1111, 1'b0, 1'b1, 4'b1000, 7, 1'b0, 1'b1};
        tbl[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 8, 1'b1, 1'b1};
        tbl[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 8, 1'b1, 1'b0};
        tbl[10] = '{4'b1111, 1'b0, 1'b1, 4'b0001, 7, 1'b0, 1'b0};
        tbl[11] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 8, 1'b1, 1'b1};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 8, 1'b1, 1'b0};
        tbl[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 7, 1'b0, 1'b0};
        tbl[14] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 7, 1'b0, 1'b0};
        tbl[15] = '{4'b0101, 1'b1, 1'b0, 4'b0000, 8, 1'b1, 1'b1};
        tbl[16] = '{4'b0101, 1'b0, 1'b0, 4'b0001, 7, 1'b0, 1'b0};
        tbl[17] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 8, 1'b1, 1'b1};

        // Directed table: fill to full, read one slot, refill, drain on empty, resume.
        apply_reset();
        for (int k = 0; k < NREQ; k++) data_i[k*WID +: WID] = 32'h1000_0000 + 32'(k);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            req_i        = tbl[i].req;
            fifo_rd_i    = tbl[i].rd;
            fifo_empty_i = tbl[i].empty;
            #1;
            chk($sformatf("tbl%0d_gnt", i),   64'(gnt_o),     64'(tbl[i].exp_gnt));
            chk($sformatf("tbl%0d_level", i), 64'(level_o),   64'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_full", i),  64'(full_o),    64'(tbl[i].exp_full));
            chk($sformatf("tbl%0d_wr", i),    64'(fifo_wr_o), 64'(tbl[i].exp_wr));
        end

        // Single request: one-cycle write latency, data held once the strobe drops.
        apply_reset();
        @(negedge clk);
        lane = 32'hDEADBEEF;
        data_i[2*WID +: WID] = lane;
        req_i = 4'b0100;
        #1;
        chk("single_gnt", 64'(gnt_o), 64'h4);
        @(negedge clk);
        req_i = '0;
        #1;
        chk("single_wr1",   64'(fifo_wr_o), 64'h1);
        chk("single_wdata", 64'(fifo_wdata_o), 64'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("single_wr0",   64'(fifo_wr_o), 64'h0);
        chk("single_hold",  64'(fifo_wdata_o), 64'hDEADBEEF);

        // Grant and valid read in the same cycle at level 3.
        apply_reset();
        req_i = 4'b1111;
        repeat (3) @(negedge clk);
        fifo_rd_i    = 1'b1;
        fifo_empty_i = 1'b0;
        #1;
        chk("bal_level_pre", 64'(level_o), 64'd3);
        chk("bal_gnt",       64'(gnt_o), 64'h8);
        @(negedge clk);
        req_i     = '0;
        fifo_rd_i = 1'b0;
        #1;
        chk("bal_level_post", 64'(level_o), 64'd3);

        // Asynchronous reset mid-burst, then restart from requester 0's position.
        apply_reset();
        req_i = 4'b1111;
        repeat (5) @(negedge clk);
        #1;
        chk("arst_level_pre", 64'(level_o), 64'd5);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_gnt",   64'(gnt_o), 64'h0);
        chk("arst_wr",    64'(fifo_wr_o), 64'h0);
        chk("arst_wdata", 64'(fifo_wdata_o), 64'h0);
        chk("arst_level", 64'(level_o), 64'h0);
        chk("arst_full",  64'(full_o), 64'h0);
        @(negedge clk);
        rst   = 1'b1;
        req_i = 4'b1010;
        #1;
        chk("arst_first_gnt", 64'(gnt_o), 64'h2);

        // Randomized run against the reference model.
        apply_reset();
        m_level = 0;
        m_ptr   = NREQ - 1;
        m_wr    = 1'b0;
        m_wdata = '0;
        rd_pct  = 30;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 200 == 0) rd_pct = $urandom_range(10, 80);
            @(negedge clk);
            req_i = NREQ'($urandom);
            for (int k = 0; k < NREQ; k++) data_i[k*WID +: WID] = $urandom;
            fifo_rd_i    = ($urandom_range(0, 99) < rd_pct);
            fifo_empty_i = ($urandom_range(0, 9) == 0);
            #1;
            w = (m_level < DEP) ? rr_pick(req_i, m_ptr) : -1;
            chk("rnd_gnt",   64'(gnt_o), (w < 0) ? 64'h0 : (64'h1 << w));
            chk("rnd_wr",    64'(fifo_wr_o), 64'(m_wr));
            chk("rnd_wdata", 64'(fifo_wdata_o), 64'(m_wdata));
            chk("rnd_level", 64'(level_o), 64'(m_level));
            chk("rnd_full",  64'(full_o), 64'(m_level == DEP));
            m_wr = (w >= 0);
            if (w >= 0) begin
                m_wdata = data_i[w*WID +: WID];
                m_ptr   = w;
            end
            m_level = m_level + ((w >= 0) ? 1 : 0)
                    - ((fifo_rd_i && !fifo_empty_i && m_level > 0) ? 1 : 0);
        end

`ifdef FIFO_WR_ARB_STATS_EN
        // Saturation of the per-requester grant counter.
        apply_reset();
        req_i        = 4'b0001;
        fifo_rd_i    = 1'b1;
        fifo_empty_i = 1'b0;
        repeat (70000) @(negedge clk);
        #1;
        chk("stats_gcnt0", 64'(grant_cnt_o[15:0]), 64'hFFFF);
        chk("stats_gcnt1", 64'(grant_cnt_o[31:16]), 64'h0);
        chk("stats_stall", 64'(stall_cnt_o), 64'h0);
        req_i = '0;
        fifo_rd_i = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
